alu_mult_seq: RTL and testbench



---
 rtl/alu_pkg.sv | 17 +
 rtl/alu_mult_seq.sv | 143 ++++++++++++++
 tb/tb_alu_mult_seq.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg
//   Shared definitions for the ALU and the blocks that drive it.
//   - ALU_OP_ADD : op code that selects addition in the ALU op decode
//   - MULT_ITER  : number of shift-add iterations for a 32x32 multiply
//   - mult_state_t : state encoding of the sequential multiplier
package alu_pkg;

  localparam logic [2:0] ALU_OP_ADD = 3'b010;
  localparam int         MULT_ITER  = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mult_state_t;

endpackage

// File: rtl/alu_mult_seq.sv
// alu_mult_seq
//   Sequential unsigned shift-add multiplier control stage. Every cycle it
//   presents the running partial-product high word and the latched
//   multiplicand to an external combinational adder. It then folds the sum
//   and carry-out back into a 2*WIDTH product register, one bit per cycle.
//
//   Optional feature macro: MULT_ZERO_SKIP_EN
//     defined   : a zero operand on start finishes at once (done after E0)
//     undefined : every multiply takes the full iteration count
//
// Ports
//   clk       rising-edge clock
//   reset     asynchronous active-high reset
//   start     multiply request, sampled only in IDLE
//   mcand     multiplicand, captured on an accepted start
//   mplier    multiplier, captured on an accepted start
//   alu_a     ALU operand 1 = current high word
//   alu_b     ALU operand 2 = latched multiplicand
//   alu_op    ALU operation, always ALU_OP_ADD
//   alu_cin   ALU carry-in, always 0
//   alu_sum   ALU result for alu_a + alu_b
//   alu_cout  ALU carry-out of the MSB
//   busy      high in CALC and DONE
//   done      one-cycle pulse when the product becomes valid
//   prod_hi   product upper word
//   prod_lo   product lower word
module alu_mult_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] mcand,
  input  logic [WIDTH-1:0] mplier,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  output logic             alu_cin,
  input  logic [WIDTH-1:0] alu_sum,
  input  logic             alu_cout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] prod_hi,
  output logic [WIDTH-1:0] prod_lo
);

  localparam logic [5:0] LAST_ITER = 6'(MULT_ITER - 1);

  mult_state_t      r_state;
  logic [5:0]       r_cnt;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_mcand;
  logic             r_busy;
  logic             r_done;

`ifdef MULT_ZERO_SKIP_EN
  logic w_zero_op;
  assign w_zero_op = (mcand == '0) || (mplier == '0);
`endif

  // The adder sees the registers directly; no pipeline stage on its inputs.
  assign alu_a   = r_hi;
  assign alu_b   = r_mcand;
  assign alu_op  = ALU_OP_ADD;
  assign alu_cin = 1'b0;

  assign busy    = r_busy;
  assign done    = r_done;
  assign prod_hi = r_hi;
  assign prod_lo = r_lo;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_mcand <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_mcand <= mcand;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
`ifdef MULT_ZERO_SKIP_EN
            if (w_zero_op) begin
              r_hi    <= '0;
              r_lo    <= '0;
              r_done  <= 1'b1;
              r_state <= DONE;
            end else begin
              r_hi    <= '0;
              r_lo    <= mplier;
              r_state <= CALC;
            end
`else
            r_hi    <= '0;
            r_lo    <= mplier;
            r_state <= CALC;
`endif
          end
        end

        CALC: begin
          // Shift the 65-bit {carry, sum, lo} (or {0, hi, lo}) right by one.
          // The carry becomes the new top bit, so nothing is truncated.
          if (r_lo[0]) begin
            r_hi <= {alu_cout, alu_sum[WIDTH-1:1]};
            r_lo <= {alu_sum[0], r_lo[WIDTH-1:1]};
          end else begin
            r_hi <= {1'b0, r_hi[WIDTH-1:1]};
            r_lo <= {r_hi[0], r_lo[WIDTH-1:1]};
          end
          r_cnt <= r_cnt + 6'd1;
          if (r_cnt == LAST_ITER) begin
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end

        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end

        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mult_seq.sv
module tb_alu_mult_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] mcand;
  logic [31:0] mplier;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_op;
  logic        alu_cin;
  logic [31:0] alu_sum;
  logic        alu_cout;
  logic        busy;
  logic        done;
  logic [31:0] prod_hi;
  logic [31:0] prod_lo;

  int errors = 0;
  int checks = 0;

`ifdef MULT_ZERO_SKIP_EN
  localparam int ZERO_LAT = 0;
`else
  localparam int ZERO_LAT = 32;
`endif
  // done is first seen after the 32nd edge following the start edge E0
  localparam int FULL_LAT = 32;

  alu_mult_seq #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .mcand    (mcand),
    .mplier   (mplier),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_op   (alu_op),
    .alu_cin  (alu_cin),
    .alu_sum  (alu_sum),
    .alu_cout (alu_cout),
    .busy     (busy),
    .done     (done),
    .prod_hi  (prod_hi),
    .prod_lo  (prod_lo)
  );

  // Behavioural 32-bit adder standing in for the carry-lookahead ALU
  logic [32:0] adder_full;
  assign adder_full = {1'b0, alu_a} + {1'b0, alu_b} + {32'd0, alu_cin};
  assign alu_sum    = adder_full[31:0];
  assign alu_cout   = adder_full[32];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present operands with start high; returns just after the start edge E0.
  task automatic do_start(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    mcand  = a;
    mplier = b;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
  endtask

  // Count edges (from 'base') until done is seen; -1 if the budget expires.
  task automatic wait_done(input int base, output int lat);
    lat = -1;
    if (done) lat = base;
    else begin
      for (int i = base + 1; i <= base + 60; i++) begin
        @(posedge clk);
        #1;
        if (done) begin
          lat = i;
          break;
        end
      end
    end
  endtask

  // Full transaction: start, latency, product, single pulse, busy fall, hold.
  task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp_prod, input int exp_lat);
    int lat;
    do_start(a, b);
    chk({tag, "_busy_rise"}, {63'd0, busy}, 64'd1);
    wait_done(0, lat);
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_prod"}, {prod_hi, prod_lo}, exp_prod);
    @(posedge clk);
    #1;
    chk({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
    chk({tag, "_busy_fall"}, {63'd0, busy}, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_hold"}, {prod_hi, prod_lo}, exp_prod);
    $display("txn %s: %0h x %0h -> %0h_%0h latency=%0d", tag, a, b, prod_hi, prod_lo, lat);
  endtask

  initial begin
    int lat;
    reset  = 1'b1;
    start  = 1'b0;
    mcand  = '0;
    mplier = '0;
    #1;
    chk("rst_busy",   {63'd0, busy},    64'd0);
    chk("rst_done",   {63'd0, done},    64'd0);
    chk("rst_prod",   {prod_hi, prod_lo}, 64'd0);
    chk("rst_alu_a",  {32'd0, alu_a},   64'd0);
    chk("rst_alu_b",  {32'd0, alu_b},   64'd0);
    chk("rst_alu_op", {61'd0, alu_op},  64'd2);
    chk("rst_cin",    {63'd0, alu_cin}, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    run_mul("3x5", 32'd3, 32'd5, 64'h0000_0000_0000_000F, FULL_LAT);
    run_mul("max_sq", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, FULL_LAT);
    run_mul("msb_x2", 32'h8000_0000, 32'd2, 64'h0000_0001_0000_0000, FULL_LAT);

    // Second start mid-CALC must be ignored
    do_start(32'd3, 32'd5);
    chk("ign_alu_b", {32'd0, alu_b}, 64'd3);
    repeat (9) @(posedge clk);
    @(negedge clk);
    mcand  = 32'd11;
    mplier = 32'd13;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    chk("ign_alu_b_kept", {32'd0, alu_b}, 64'd3);
    wait_done(10, lat);
    chk("ign_latency", 64'(lat), 64'(FULL_LAT));
    chk("ign_prod", {prod_hi, prod_lo}, 64'd15);
    @(posedge clk);
    #1;
    chk("ign_single_done", {63'd0, done}, 64'd0);
    $display("txn ignore_start: 3 x 5 (11 x 13 ignored) -> %0h_%0h latency=%0d", prod_hi, prod_lo, lat);

    // Asynchronous reset mid-CALC
    do_start(32'h1234_5678, 32'h9ABC_DEF0);
    repeat (9) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_busy",  {63'd0, busy}, 64'd0);
    chk("arst_done",  {63'd0, done}, 64'd0);
    chk("arst_prod",  {prod_hi, prod_lo}, 64'd0);
    chk("arst_alu_b", {32'd0, alu_b}, 64'd0);
    $display("txn async_reset: busy=%0b done=%0b prod=%0h_%0h", busy, done, prod_hi, prod_lo);
    @(negedge clk);
    reset = 1'b0;
    run_mul("7x9", 32'd7, 32'd9, 64'd63, FULL_LAT);

    run_mul("zero", 32'd0, 32'h1234, 64'd0, ZERO_LAT);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
